// File: rtl/nlfsr_period_scanner_pkg.sv
// Shared types and helpers for the multi-lane NLFSR period scanner.
package nlfsr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } scan_state_e;

  localparam int unsigned MaxSize = 24;

  // 2**size, wide enough for the largest supported register.
  function automatic logic [MaxSize:0] full_period(input int unsigned size);
    return (MaxSize + 1)'(1) << size;
  endfunction

endpackage

// File: rtl/nlfsr_period_scanner_if.sv
// Selector/collector-facing signal bundle of the period scanner.
interface nlfsr_period_scanner_if #(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned CHANNELS = 4
) ();

  logic                         start;
  logic                         ena;
  logic                         selector_done;
  logic [SIZE-1:0]              seed;
  logic [CHANNELS-1:0]          feedback;
  logic [CHANNELS*SIZE-1:0]     state;
  logic [CHANNELS-1:0]          found;
  logic [CHANNELS-1:0]          failure;
  logic [CHANNELS*(SIZE+1)-1:0] period;
  logic                         busy;
  logic                         done;

  modport master (
    output start, ena, selector_done, seed, feedback,
    input  state, found, failure, period, busy, done
  );

  modport slave (
    input  start, ena, selector_done, seed, feedback,
    output state, found, failure, period, busy, done
  );

endinterface

// File: rtl/nlfsr_period_scanner_lane.sv
// One NLFSR lane: shift register plus sticky verdict and period capture.
module nlfsr_lane
  import nlfsr_pkg::*;
#(
  parameter int unsigned SIZE = 16
) (
  input  logic            clk,
  input  logic            res,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [SIZE-1:0] load_seed_i,
  input  logic [SIZE-1:0] ref_seed_i,
  input  logic [SIZE:0]   count_i,
  input  logic            feedback_i,
  output logic [SIZE-1:0] state_o,
  output logic            found_o,
  output logic            failure_o,
  output logic [SIZE:0]   period_o,
  output logic            resolved_o,
  output logic            resolve_o
);

  localparam logic [SIZE:0] FullPeriod = (SIZE + 1)'(full_period(SIZE));

  logic [SIZE-1:0] state_q, state_d, next_state;
  logic            found_q, found_d;
  logic            failure_q, failure_d;
  logic [SIZE:0]   period_q, period_d;
  logic            resolved, hit, at_full;

  assign resolved   = found_q | failure_q;
  assign next_state = {feedback_i ^ state_q[0], state_q[SIZE-1:1]};
  assign hit        = (next_state == ref_seed_i);
  assign at_full    = (count_i == FullPeriod);
  // Lane resolves on this edge; lets the top leave RUN without an extra cycle.
  assign resolve_o  = step_i & ~resolved & (hit | at_full);

  always_comb begin
    state_d   = state_q;
    found_d   = found_q;
    failure_d = failure_q;
    period_d  = period_q;
    if (load_i) begin
      state_d   = load_seed_i;
      found_d   = 1'b0;
      failure_d = 1'b0;
      period_d  = '0;
    end else if (step_i && !resolved) begin
      state_d = next_state;
      if (hit) begin
        found_d   = at_full;
        failure_d = ~at_full;
        period_d  = count_i;
      end else if (at_full) begin
        failure_d = 1'b1;
        period_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= '1;
      found_q   <= 1'b0;
      failure_q <= 1'b0;
      period_q  <= '0;
    end else begin
      state_q   <= state_d;
      found_q   <= found_d;
      failure_q <= failure_d;
      period_q  <= period_d;
    end
  end

  assign state_o    = state_q;
  assign found_o    = found_q;
  assign failure_o  = failure_q;
  assign period_o   = period_q;
  assign resolved_o = resolved;

endmodule

// File: rtl/nlfsr_period_scanner.sv
// Multi-lane NLFSR full-period checker: scan FSM, seed register, shared step counter.
module nlfsr_period_scanner
  import nlfsr_pkg::*;
#(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned CHANNELS = 4
) (
  input logic                   clk,
  input logic                   res,
  nlfsr_period_scanner_if.slave bus
);

  scan_state_e     st_q, st_d;
  logic [SIZE-1:0] seed_q, seed_d;
  logic [SIZE:0]   count_q, count_d, count_next;
  logic            step;

  logic [CHANNELS-1:0]           lane_resolved, lane_resolve;
  logic [CHANNELS-1:0][SIZE-1:0] lane_state;
  logic [CHANNELS-1:0][SIZE:0]   lane_period;

  // start takes priority over a step in the same cycle.
  assign step       = (st_q == StRun) & bus.ena & bus.selector_done & ~bus.start;
  assign count_next = count_q + 1'b1;

  always_comb begin
    st_d    = st_q;
    seed_d  = seed_q;
    count_d = count_q;
    if (bus.start) begin
      st_d    = StRun;
      seed_d  = bus.seed;
      count_d = '0;
    end else if (step) begin
      count_d = count_next;
      if (&(lane_resolved | lane_resolve)) begin
        st_d = StDone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      st_q    <= StIdle;
      seed_q  <= '0;
      count_q <= '0;
    end else begin
      st_q    <= st_d;
      seed_q  <= seed_d;
      count_q <= count_d;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    nlfsr_lane #(
      .SIZE (SIZE)
    ) u_lane (
      .clk         (clk),
      .res         (res),
      .load_i      (bus.start),
      .step_i      (step),
      .load_seed_i (bus.seed),
      .ref_seed_i  (seed_q),
      .count_i     (count_next),
      .feedback_i  (bus.feedback[k]),
      .state_o     (lane_state[k]),
      .found_o     (bus.found[k]),
      .failure_o   (bus.failure[k]),
      .period_o    (lane_period[k]),
      .resolved_o  (lane_resolved[k]),
      .resolve_o   (lane_resolve[k])
    );
  end

  assign bus.state  = lane_state;
  assign bus.period = lane_period;
  assign bus.busy   = (st_q == StRun);
  assign bus.done   = (st_q == StDone);

endmodule

// File: tb/tb_nlfsr_period_scanner.sv
// Scoreboard bench: 4-bit/2-lane scanner for the main scenarios, 16-bit/1-lane for the long scan.
module tb_nlfsr_period_scanner;

  typedef struct {
    logic        found;
    logic        failure;
    logic [16:0] period;
  } exp_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   mode0 = 0;
  int   mode1 = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nlfsr_period_scanner_if #(.SIZE(4), .CHANNELS(2))  bus4 ();
  nlfsr_period_scanner_if #(.SIZE(16), .CHANNELS(1)) bus16 ();

  nlfsr_period_scanner #(.SIZE(4), .CHANNELS(2)) dut4 (
    .clk (clk),
    .res (res),
    .bus (bus4)
  );

  nlfsr_period_scanner #(.SIZE(16), .CHANNELS(1)) dut16 (
    .clk (clk),
    .res (res),
    .bus (bus16)
  );

  // Full-period de Bruijn functions: maximal LFSR with the all-zero state spliced in.
  function automatic logic golden4(input logic [3:0] s);
    return s[1] ^ (s[3:1] == 3'b000);
  endfunction

  function automatic logic golden16(input logic [15:0] s);
    return s[2] ^ s[3] ^ s[5] ^ (s[15:1] == 15'd0);
  endfunction

  function automatic logic fb4(input int mode, input logic [3:0] s);
    case (mode)
      1:       return golden4(s);
      2:       return s[0];
      default: return 1'b0;
    endcase
  endfunction

  assign bus4.feedback  = {fb4(mode1, bus4.state[7:4]), fb4(mode0, bus4.state[3:0])};
  assign bus16.feedback = golden16(bus16.state);

  task automatic start4(input logic [3:0] s);
    @(negedge clk);
    bus4.seed  = s;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  task automatic wait_done(input bit wide, input int budget, output int n);
    n = 0;
    while (!(wide ? bus16.done : bus4.done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) n = -1;
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus4.state !== 8'hFF || bus16.state !== 16'hFFFF) begin
      bad++; $display("FAIL reset_state got %h/%h want ff/ffff", bus4.state, bus16.state);
    end
    total++;
    if ({bus4.found, bus4.failure, bus4.period, bus4.busy, bus4.done} !== 16'h0) begin
      bad++; $display("FAIL reset_flags got %h want 0",
                      {bus4.found, bus4.failure, bus4.period, bus4.busy, bus4.done});
    end
    res = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_period();
    int n;
    exp_t e;
    mode0 = 1; mode1 = 0;
    sb.push_back('{1'b1, 1'b0, 17'd16});
    sb.push_back('{1'b0, 1'b1, 17'd1});
    start4(4'hF);
    @(negedge clk);
    total++;
    if ({bus4.found, bus4.failure, bus4.period[9:5], bus4.done} !== {2'b00, 2'b10, 5'd1, 1'b0})
    begin
      bad++; $display("FAIL lane1_step1 got f=%b x=%b p=%0d want f=00 x=10 p=1",
                      bus4.found, bus4.failure, bus4.period[9:5]);
    end
    wait_done(0, 40, n);
    total++;
    if (n !== 15) begin bad++; $display("FAIL full_latency got %0d want 15", n); end
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      total++;
      if ({bus4.found[k], bus4.failure[k], bus4.period[k*5 +: 5]}
          !== {e.found, e.failure, e.period[4:0]}) begin
        bad++; $display("FAIL full_lane%0d got %b%b p=%0d want %b%b p=%0d", k, bus4.found[k],
                        bus4.failure[k], bus4.period[k*5 +: 5], e.found, e.failure, e.period);
      end
    end
    // Steps in DONE must be ignored.
    repeat (3) @(negedge clk);
    total++;
    if ({bus4.state, bus4.found, bus4.failure, bus4.done, bus4.busy} !== {8'hFF, 2'b01, 2'b10,
        1'b1, 1'b0}) begin
      bad++; $display("FAIL done_hold got st=%h f=%b x=%b d=%b", bus4.state, bus4.found,
                      bus4.failure, bus4.done);
    end
  endtask

  task automatic test_rotation();
    int n;
    exp_t e;
    mode0 = 0; mode1 = 0;
    sb.push_back('{1'b0, 1'b1, 17'd4});
    sb.push_back('{1'b0, 1'b1, 17'd4});
    start4(4'h1);
    wait_done(0, 40, n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL rot_latency got %0d want 4", n); end
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      total++;
      if ({bus4.found[k], bus4.failure[k], bus4.period[k*5 +: 5]}
          !== {e.found, e.failure, e.period[4:0]}) begin
        bad++; $display("FAIL rot_lane%0d got %b%b p=%0d want %b%b p=%0d", k, bus4.found[k],
                        bus4.failure[k], bus4.period[k*5 +: 5], e.found, e.failure, e.period);
      end
    end
  endtask

  task automatic test_collapse();
    int n;
    exp_t e;
    mode0 = 2; mode1 = 1;
    sb.push_back('{1'b0, 1'b1, 17'd0});
    sb.push_back('{1'b1, 1'b0, 17'd16});
    start4(4'hF);
    wait_done(0, 40, n);
    total++;
    if (n !== 16) begin bad++; $display("FAIL col_latency got %0d want 16", n); end
    total++;
    if (bus4.state[3:0] !== 4'h0) begin
      bad++; $display("FAIL col_state got %h want 0", bus4.state[3:0]);
    end
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      total++;
      if ({bus4.found[k], bus4.failure[k], bus4.period[k*5 +: 5]}
          !== {e.found, e.failure, e.period[4:0]}) begin
        bad++; $display("FAIL col_lane%0d got %b%b p=%0d want %b%b p=%0d", k, bus4.found[k],
                        bus4.failure[k], bus4.period[k*5 +: 5], e.found, e.failure, e.period);
      end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    int steps = 0;
    int st_bad = 0;
    logic [3:0] m0 = 4'hF;
    exp_t e;
    mode0 = 1; mode1 = 0;
    sb.push_back('{1'b1, 1'b0, 17'd16});
    start4(4'hF);
    while (!bus4.done && n < 80) begin
      bus4.selector_done = n[0];
      @(negedge clk);
      n++;
      if (bus4.selector_done && steps < 16) begin
        m0 = {golden4(m0) ^ m0[0], m0[3:1]};
        steps++;
      end
      total++;
      if (bus4.state !== {4'hF, m0}) begin
        bad++; st_bad++;
        if (st_bad < 4) $display("FAIL stall_state cyc=%0d got %h want %h", n, bus4.state,
                                 {4'hF, m0});
      end
    end
    bus4.selector_done = 1'b1;
    total++;
    if (n !== 32) begin bad++; $display("FAIL stall_latency got %0d want 32", n); end
    e = sb.pop_front();
    total++;
    if ({bus4.found[0], bus4.failure[0], bus4.period[4:0]} !== {e.found, e.failure,
        e.period[4:0]}) begin
      bad++; $display("FAIL stall_lane0 got %b%b p=%0d want 10 p=16", bus4.found[0],
                      bus4.failure[0], bus4.period[4:0]);
    end
  endtask

  task automatic test_abort();
    int n;
    exp_t e;
    mode0 = 1; mode1 = 0;
    start4(4'hF);
    repeat (7) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    total++;
    if ({bus4.state, bus4.found, bus4.failure, bus4.period, bus4.busy, bus4.done}
        !== {8'hFF, 16'h0}) begin
      bad++; $display("FAIL mid_reset got st=%h f=%b x=%b b=%b d=%b", bus4.state, bus4.found,
                      bus4.failure, bus4.busy, bus4.done);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({bus4.state, bus4.busy} !== {8'hFF, 1'b0}) begin
      bad++; $display("FAIL idle_hold got st=%h b=%b want ff 0", bus4.state, bus4.busy);
    end
    start4(4'hF);
    repeat (7) @(negedge clk);
    sb.push_back('{1'b1, 1'b0, 17'd16});
    sb.push_back('{1'b0, 1'b1, 17'd1});
    start4(4'hF);
    total++;
    if ({bus4.state, bus4.found, bus4.failure, bus4.busy} !== {8'hFF, 4'b0, 1'b1}) begin
      bad++; $display("FAIL restart got st=%h f=%b x=%b b=%b", bus4.state, bus4.found,
                      bus4.failure, bus4.busy);
    end
    wait_done(0, 40, n);
    total++;
    if (n !== 16) begin bad++; $display("FAIL restart_latency got %0d want 16", n); end
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      total++;
      if ({bus4.found[k], bus4.failure[k], bus4.period[k*5 +: 5]}
          !== {e.found, e.failure, e.period[4:0]}) begin
        bad++; $display("FAIL restart_lane%0d got %b%b p=%0d want %b%b p=%0d", k,
                        bus4.found[k], bus4.failure[k], bus4.period[k*5 +: 5], e.found,
                        e.failure, e.period);
      end
    end
  endtask

  task automatic test_wide();
    int n;
    exp_t e;
    sb.push_back('{1'b1, 1'b0, 17'h10000});
    @(negedge clk);
    bus16.seed  = 16'hACE1;
    bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    wait_done(1, 70000, n);
    total++;
    if (n !== 65536) begin bad++; $display("FAIL wide_latency got %0d want 65536", n); end
    e = sb.pop_front();
    total++;
    if ({bus16.found, bus16.failure, bus16.period, bus16.state}
        !== {e.found, e.failure, e.period, 16'hACE1}) begin
      bad++; $display("FAIL wide_result got f=%b x=%b p=%0d st=%h want 1 0 65536 ace1",
                      bus16.found, bus16.failure, bus16.period, bus16.state);
    end
  endtask

  initial begin
    bus4.start = 1'b0;  bus4.ena = 1'b1;  bus4.selector_done = 1'b1;  bus4.seed = '0;
    bus16.start = 1'b0; bus16.ena = 1'b1; bus16.selector_done = 1'b1; bus16.seed = '0;
    test_reset();
    test_full_period();
    test_rotation();
    test_collapse();
    test_stall();
    test_abort();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
